// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared aluop codes, arbiter FSM states and legal-op check
//
// Purpose : definitions shared by alu_arbiter and alu_rr_arb2.
// Ports   : none (package).
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_NOR: is_legal_op = 1'b1;
      default:                                              is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// rtl/alu_rr_arb2.sv - 2-way round-robin grant with last-grant pointer
//
// Purpose : picks one of two requesters; on a tie the one not granted last wins.
// Ports   : clk, rst_n          clock, async active-low reset
//           i_req[1:0]          request vector
//           i_accept            grant was taken this cycle; update the pointer
//           o_grant[1:0]        combinational one-hot (or zero) grant
module alu_rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  // 1 = port 1 was granted last; resets to 1 so port 0 wins the first tie.
  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two valid/ready requesters
//
// Purpose : round-robin arbiter, one op in flight; IDLE -> EXEC -> RESP.
//           Optional grant statistics enabled by macro ALU_ARB_STATS_EN.
// Ports   : CLK, RESET_N                     clock, async active-low reset
//           req_valid/req_ready[1:0]         request handshake per port
//           req{0,1}_op/_a/_b                request payload per port
//           rsp_valid/rsp_ready[1:0]         response handshake per port
//           rsp_result/rsp_zero/rsp_err      registered shared response
//           alu_op/alu_a/alu_b               to external ALU (issue registers)
//           alu_result/alu_zero              from external ALU
//           stat_grant0/stat_grant1          saturating grant counters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [15:0]      stat_grant0,
  output logic [15:0]      stat_grant1
);

  arb_state_t       r_state;
  logic [OPW-1:0]   r_issue_op;
  logic [WIDTH-1:0] r_issue_a;
  logic [WIDTH-1:0] r_issue_b;
  logic             r_issue_err;
  logic             r_id;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  logic [1:0]       w_grant;
  logic             w_accept;
  logic [OPW-1:0]   w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_legal;

  alu_rr_arb2 u_rr (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // A grant is only offered in IDLE; reset also forces ready low since the
  // state register alone would leave IDLE's combinational ready exposed.
  assign w_accept    = RESET_N && (r_state == IDLE) && (w_grant != 2'b00);
  assign req_ready   = w_accept ? w_grant : 2'b00;

  assign w_sel_op    = w_grant[1] ? req1_op : req0_op;
  assign w_sel_a     = w_grant[1] ? req1_a  : req0_a;
  assign w_sel_b     = w_grant[1] ? req1_b  : req0_b;
  assign w_sel_legal = is_legal_op(w_sel_op);

  assign alu_op      = r_issue_op;
  assign alu_a       = r_issue_a;
  assign alu_b       = r_issue_b;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_err     = r_rsp_err;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= IDLE;
      r_issue_op   <= '0;
      r_issue_a    <= '0;
      r_issue_b    <= '0;
      r_issue_err  <= 1'b0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Illegal ops are issued as ADD so the ALU sees a defined code.
            r_issue_op  <= w_sel_legal ? w_sel_op : '0;
            r_issue_a   <= w_sel_a;
            r_issue_b   <= w_sel_b;
            r_issue_err <= !w_sel_legal;
            r_id        <= w_grant[1];
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= r_issue_err ? '0 : alu_result;
          r_rsp_zero   <= r_issue_err ? 1'b1 : alu_zero;
          r_rsp_err    <= r_issue_err;
          r_rsp_valid  <= r_id ? 2'b10 : 2'b01;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_id]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_stat0;
  logic [15:0] r_stat1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else if (w_accept) begin
      if (w_grant[0] && (r_stat0 != 16'hFFFF)) r_stat0 <= r_stat0 + 16'd1;
      if (w_grant[1] && (r_stat1 != 16'hFFFF)) r_stat1 <= r_stat1 + 16'd1;
    end
  end

  assign stat_grant0 = r_stat0;
  assign stat_grant1 = r_stat1;
`else
  assign stat_grant0 = 16'd0;
  assign stat_grant1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU beside it
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_zero, rsp_err, alu_zero;
  logic [15:0] stat_grant0, stat_grant1;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: last granted port and grant counts.
  int m_last = 1;
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
  );

  function automatic bit ref_legal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0010) || (op == 4'b1010) || (op == 4'b0100) ||
           (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0010: return a - b;
      4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered just after a rising edge with the DUT in IDLE; returns just after
  // the rising edge that completes the response handshake.
  task automatic run_txn(input logic [1:0] v,
                         input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input int bp, input logic [1:0] eg,
                         input logic [31:0] er, input logic ez, input logic ee);
    logic [3:0]  gop;
    logic [31:0] ga, gb;
    req_valid = v;
    req0_op = op0; req0_a = a0; req0_b = b0;
    req1_op = op1; req1_a = a1; req1_b = b1;
    gop = eg[1] ? op1 : op0;
    ga  = eg[1] ? a1  : a0;
    gb  = eg[1] ? b1  : b0;
    @(negedge CLK);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("grant", 32'(req_ready), 32'(eg));
    @(posedge CLK); #1;
    req_valid = 2'b00;
    m_last = eg[1] ? 1 : 0;
    if (eg[0]) m_cnt0++; else m_cnt1++;
    @(negedge CLK);
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("alu_op", 32'(alu_op), ref_legal(gop) ? 32'(gop) : 32'd0);
    chk("alu_a", alu_a, ga);
    chk("alu_b", alu_b, gb);
    @(negedge CLK);
    chk("rsp_valid", 32'(rsp_valid), 32'(eg));
    chk("rsp_result", rsp_result, er);
    chk("rsp_zero", 32'(rsp_zero), 32'(ez));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("resp_ready", 32'(req_ready), 32'd0);
    if (bp > 0) begin
      rsp_ready = ~eg;
      req_valid = 2'b11;
      for (int i = 0; i < bp; i++) begin
        @(negedge CLK);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'(eg));
        chk("bp_result", rsp_result, er);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
    end
    rsp_ready = eg;
    @(posedge CLK); #1;
    rsp_ready = 2'b00;
    req_valid = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  op0;
    logic [31:0] a0, b0;
    logic [3:0]  op1;
    logic [31:0] a1, b1;
    int          bp;
    logic [1:0]  eg;
    logic [31:0] er;
    logic        ez, ee;
  } vec_t;

  vec_t        tbl[10];
  logic [3:0]  op_pool[9];
  logic [1:0]  rv, eg;
  logic [3:0]  rop0, rop1, gop;
  logic [31:0] ra0, rb0, ra1, rb1, ga, gb, er;
  logic [15:0] exp_s0, exp_s1;

  initial begin
    tbl[0] = '{2'b11, 4'b0010, 32'd9, 32'd9, 4'b1010, 32'd3, 32'd4, 0, 2'b01, 32'd0, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 4'b0010, 32'd9, 32'd9, 4'b1010, 32'd3, 32'd4, 0, 2'b10, 32'd1, 1'b0, 1'b0};
    tbl[2] = '{2'b11, 4'b0010, 32'd9, 32'd9, 4'b1010, 32'd3, 32'd4, 0, 2'b01, 32'd0, 1'b1, 1'b0};
    tbl[3] = '{2'b01, 4'b0000, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0, 0, 2'b01, 32'd12, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 4'b0000, 32'd0, 32'd0, 4'b1111, 32'd3, 32'd4, 0, 2'b10, 32'd0, 1'b1, 1'b1};
    tbl[5] = '{2'b10, 4'b0000, 32'd0, 32'd0, 4'b0101, 32'hF0, 32'h0F, 5, 2'b10, 32'hFF, 1'b0, 1'b0};
    tbl[6] = '{2'b11, 4'b0110, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0100, 32'd1, 32'd1, 0, 2'b01, 32'hF00FF00F, 1'b0, 1'b0};
    tbl[7] = '{2'b11, 4'b0110, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0111, 32'd0, 32'd0, 0, 2'b10, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[8] = '{2'b01, 4'b1010, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'd0, 32'd0, 0, 2'b01, 32'd1, 1'b0, 1'b0};
    tbl[9] = '{2'b10, 4'b0000, 32'd0, 32'd0, 4'b0010, 32'd0, 32'd1, 2, 2'b10, 32'hFFFFFFFF, 1'b0, 1'b0};
    op_pool = '{4'b0000, 4'b0010, 4'b1010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1111, 4'b0001};

    RESET_N = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req0_op = 4'd0; req1_op = 4'd0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_stat0", 32'(stat_grant0), 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].v, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1, tbl[i].b1,
              tbl[i].bp, tbl[i].eg, tbl[i].er, tbl[i].ez, tbl[i].ee);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      rv   = 2'($urandom_range(1, 3));
      rop0 = op_pool[$urandom_range(0, 8)];
      rop1 = op_pool[$urandom_range(0, 8)];
      ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
      if ($urandom_range(0, 3) == 0) rb0 = ra0;
      if ($urandom_range(0, 3) == 0) rb1 = ra1;
      if (rv == 2'b11) eg = (m_last == 1) ? 2'b01 : 2'b10;
      else             eg = rv;
      gop = eg[1] ? rop1 : rop0;
      ga  = eg[1] ? ra1 : ra0;
      gb  = eg[1] ? rb1 : rb0;
      er  = ref_legal(gop) ? ref_alu(gop, ga, gb) : 32'd0;
      run_txn(rv, rop0, ra0, rb0, rop1, ra1, rb1, int'($urandom_range(0, 2)), eg,
              er, (er == 32'd0), !ref_legal(gop));
    end

`ifdef ALU_ARB_STATS_EN
    exp_s0 = 16'(m_cnt0); exp_s1 = 16'(m_cnt1);
`else
    exp_s0 = 16'd0; exp_s1 = 16'd0;
`endif
    chk("stat0_model", 32'(stat_grant0), 32'(exp_s0));
    chk("stat1_model", 32'(stat_grant1), 32'(exp_s1));

    // Reset while in EXEC: everything clears at once, no response follows.
    req_valid = 2'b01; req0_op = 4'b0010; req0_a = 32'd9; req0_b = 32'd3;
    @(negedge CLK);
    chk("pre_rst_grant", 32'(req_ready), 32'd1);
    @(posedge CLK); #1;
    req_valid = 2'b11;
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_stat0", 32'(stat_grant0), 32'd0);
    req_valid = 2'b00;
    m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge CLK); #1;

    // Three port-0 and two port-1 grants from a fresh reset.
    run_txn(2'b11, 4'b0000, 32'd1, 32'd2, 4'b0000, 32'd3, 32'd4, 0, 2'b01, 32'd3, 1'b0, 1'b0);
    run_txn(2'b11, 4'b0000, 32'd1, 32'd2, 4'b0000, 32'd3, 32'd4, 0, 2'b10, 32'd7, 1'b0, 1'b0);
    run_txn(2'b11, 4'b0000, 32'd1, 32'd2, 4'b0000, 32'd3, 32'd4, 0, 2'b01, 32'd3, 1'b0, 1'b0);
    run_txn(2'b01, 4'b0100, 32'hF0, 32'h0F, 4'b0000, 32'd0, 32'd0, 0, 2'b01, 32'd0, 1'b1, 1'b0);
    run_txn(2'b10, 4'b0000, 32'd0, 32'd0, 4'b1110, 32'd5, 32'd5, 0, 2'b10, 32'd0, 1'b1, 1'b1);
    @(negedge CLK);
`ifdef ALU_ARB_STATS_EN
    exp_s0 = 16'd3; exp_s1 = 16'd2;
`else
    exp_s0 = 16'd0; exp_s1 = 16'd0;
`endif
    chk("stat0_fixed", 32'(stat_grant0), 32'(exp_s0));
    chk("stat1_fixed", 32'(stat_grant1), 32'(exp_s1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
